// File: rtl/ad1_pkg.sv
// ad1_pkg: shared types and constants for the Pmod AD1 sample scheduler.
// Frame geometry, result widths and the reserved timer source id.
package ad1_pkg;

    localparam int ID_W      = 4;
    localparam int FRAME_LEN = 16;
    localparam int DATA_W    = 12;

    localparam logic [ID_W-1:0] TIMER_ID = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_SHIFT = 3'd2,
        ST_QUIET = 3'd3,
        ST_OUT   = 3'd4
    } ad1_state_e;

endpackage

// File: rtl/ad1_rr_arbiter.sv
// ad1_rr_arbiter: round-robin grant among external sample requesters.
// The pointer moves to one past the last granted index.
module ad1_rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_en,
    input  logic [NUM_REQ-1:0] i_req,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [3:0]         o_idx
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_nptr;
    logic [PW-1:0] w_sel;
    logic          w_found;
    int            w_k;

    // Scan from the pointer, wrapping once, for the first active request
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_nptr  = r_ptr;
        w_k     = 0;
        w_sel   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_k = int'(r_ptr) + i;
            if (w_k >= NUM_REQ) begin
                w_k = w_k - NUM_REQ;
            end
            w_sel = PW'(w_k);
            if (i_en && !w_found && i_req[w_sel]) begin
                w_found      = 1'b1;
                o_gnt[w_sel] = 1'b1;
                o_idx        = 4'(w_k);
                w_nptr       = (w_k == NUM_REQ - 1) ? '0 : PW'(w_k + 1);
            end
        end
    end

    // Advance the pointer only when a grant is actually issued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_found) begin
            r_ptr <= w_nptr;
        end
    end

endmodule

// File: rtl/ad1_sample_sched.sv
// ad1_sample_sched: arbitrates requesters and a periodic timer onto one
// Pmod AD1 converter, runs the serial frame and hands back the result.
module ad1_sample_sched
    import ad1_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int CLK_DIV   = 4,
    parameter int QUIET_CYC = 8,
    parameter int DUAL_MODE = 1
) (
    input  logic               s_axi_aclk,
    input  logic               s_axi_aresetn,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    input  logic [15:0]        period,
    output logic               smp_valid,
    input  logic               smp_ready,
    output logic [ID_W-1:0]    smp_id,
    output logic [DATA_W-1:0]  smp_ch0,
    output logic [DATA_W-1:0]  smp_ch1,
    output logic               overrun,
    input  logic               clr_overrun,
    output logic               busy,
    output logic               SCK,
    output logic               CS,
    input  logic               D0,
    input  logic               D1
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int QW = (QUIET_CYC > 1) ? $clog2(QUIET_CYC) : 1;
    localparam int EW = $clog2(FRAME_LEN + 1);

    ad1_state_e        r_state;
    ad1_state_e        w_nxt;
    logic              r_rdy;
    logic [DW-1:0]     r_div;
    logic              r_hi;
    logic [EW-1:0]     r_edges;
    logic [QW-1:0]     r_qcnt;
    logic [DATA_W-1:0] r_sh0;
    logic [DATA_W-1:0] r_sh1;
    logic [DATA_W-1:0] r_ch0;
    logic [DATA_W-1:0] r_ch1;
    logic [ID_W-1:0]   r_src;
    logic [ID_W-1:0]   r_id;
    logic [15:0]       r_tmr;
    logic              r_pend;
    logic              r_ovr;

    logic              w_idle;
    logic              w_take;
    logic              w_tmr_gnt;
    logic              w_arb_en;
    logic              w_div_end;
    logic              w_rise;
    logic              w_shift_done;
    logic              w_q_end;
    logic              w_tick;
    logic [NUM_REQ-1:0] w_arb_gnt;
    logic [3:0]        w_arb_idx;

    assign w_idle       = (r_state == ST_IDLE);
    assign w_take       = w_idle && r_rdy && (r_pend || (|req));
    assign w_tmr_gnt    = w_idle && r_rdy && r_pend;
    assign w_arb_en     = w_idle && r_rdy && !r_pend;
    assign w_div_end    = (r_div == DW'(CLK_DIV - 1));
    assign w_rise       = (r_state == ST_SHIFT) && w_div_end && !r_hi;
    assign w_shift_done = w_div_end && r_hi && (r_edges == EW'(FRAME_LEN));
    assign w_q_end      = (r_qcnt == QW'(QUIET_CYC - 1));
    assign w_tick       = (period != 16'd0) && (r_tmr == 16'd1);

    ad1_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk   (s_axi_aclk),
        .rst_n (s_axi_aresetn),
        .i_en  (w_arb_en),
        .i_req (req),
        .o_gnt (w_arb_gnt),
        .o_idx (w_arb_idx)
    );

    // State register; r_rdy keeps grants off while reset is held
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_state <= ST_IDLE;
            r_rdy   <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_rdy   <= 1'b1;
        end
    end

    // Next-state decode for one conversion frame
    always_comb begin
        w_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_take) w_nxt = ST_START;
            ST_START: w_nxt = ST_SHIFT;
            ST_SHIFT: if (w_shift_done) w_nxt = ST_QUIET;
            ST_QUIET: if (w_q_end) w_nxt = ST_OUT;
            ST_OUT:   if (smp_ready) w_nxt = ST_IDLE;
            default:  w_nxt = ST_IDLE;
        endcase
    end

    // SCK divider, rising-edge count and MSB-first capture of both lines
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_div   <= '0;
            r_hi    <= 1'b0;
            r_edges <= '0;
            r_sh0   <= '0;
            r_sh1   <= '0;
        end else if (r_state != ST_SHIFT) begin
            r_div   <= '0;
            r_hi    <= 1'b0;
            r_edges <= '0;
        end else if (w_div_end) begin
            r_div <= '0;
            r_hi  <= ~r_hi;
            if (w_rise) begin
                r_edges <= r_edges + 1'b1;
                r_sh0   <= {r_sh0[DATA_W-2:0], D0};
                r_sh1   <= {r_sh1[DATA_W-2:0], D1};
            end
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // Chip-select high time between frames
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_qcnt <= '0;
        end else if (r_state != ST_QUIET) begin
            r_qcnt <= '0;
        end else begin
            r_qcnt <= r_qcnt + 1'b1;
        end
    end

    // Source latched at grant, results presented together on entry to OUT
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_src <= '0;
            r_id  <= '0;
            r_ch0 <= '0;
            r_ch1 <= '0;
        end else begin
            if (w_take) begin
                r_src <= r_pend ? TIMER_ID : w_arb_idx;
            end
            if ((r_state == ST_QUIET) && w_q_end) begin
                r_id  <= r_src;
                r_ch0 <= r_sh0;
                r_ch1 <= (DUAL_MODE != 0) ? r_sh1 : '0;
            end
        end
    end

    // Period timer; a zero count after reset just loads the period
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_tmr <= '0;
        end else if (period != 16'd0) begin
            if (r_tmr <= 16'd1) begin
                r_tmr <= period;
            end else begin
                r_tmr <= r_tmr - 16'd1;
            end
        end
    end

    // Pending tick and sticky overrun when a tick finds one still waiting
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_pend <= 1'b0;
            r_ovr  <= 1'b0;
        end else begin
            if (w_tick) begin
                r_pend <= 1'b1;
            end else if (w_tmr_gnt) begin
                r_pend <= 1'b0;
            end
            if (w_tick && r_pend && !w_tmr_gnt) begin
                r_ovr <= 1'b1;
            end else if (clr_overrun) begin
                r_ovr <= 1'b0;
            end
        end
    end

    assign gnt       = w_arb_gnt;
    assign busy      = !w_idle;
    assign smp_valid = (r_state == ST_OUT);
    assign smp_id    = r_id;
    assign smp_ch0   = r_ch0;
    assign smp_ch1   = r_ch1;
    assign overrun   = r_ovr;
    assign CS        = !((r_state == ST_START) || (r_state == ST_SHIFT));
    assign SCK       = !((r_state == ST_SHIFT) && !r_hi);

endmodule

// File: tb/tb_ad1_sample_sched.sv
// tb_ad1_sample_sched: scoreboard bench for the AD1 sample scheduler.
// A second instance runs single-channel mode on the same stimulus.
module tb_ad1_sample_sched;

    typedef struct {
        logic [3:0]  id;
        logic [11:0] c0;
        logic [11:0] c1;
        int          gcyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [15:0] period = 16'd0;
    logic        smp_ready = 1'b1;
    logic        clr = 1'b0;
    logic        d0;
    logic        d1;

    logic [1:0]  gnt;
    logic        smp_valid;
    logic [3:0]  smp_id;
    logic [11:0] ch0;
    logic [11:0] ch1;
    logic        overrun;
    logic        busy;
    logic        sck;
    logic        cs;

    logic [1:0]  g2;
    logic        v2;
    logic [3:0]  id2;
    logic [11:0] c20;
    logic [11:0] c21;
    logic        ov2;
    logic        b2;
    logic        sck2;
    logic        cs2;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int bidx = 0;
    int m_ptr = 0;
    int v_cyc = 0;
    int g_cnt = 0;
    int v_cnt = 0;
    logic [15:0] f0 = 16'h0AC3;
    logic [15:0] f1 = 16'h0F5A;
    logic        p_busy = 1'b0;
    logic        p_valid = 1'b0;
    logic [1:0]  p_req = 2'b00;
    logic [1:0]  p_gnt = 2'b00;
    exp_t        sb[$];
    int          t_g[$];

    ad1_sample_sched #(
        .NUM_REQ(2), .CLK_DIV(4), .QUIET_CYC(8), .DUAL_MODE(1)
    ) dut (
        .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
        .req(req), .gnt(gnt), .period(period),
        .smp_valid(smp_valid), .smp_ready(smp_ready),
        .smp_id(smp_id), .smp_ch0(ch0), .smp_ch1(ch1),
        .overrun(overrun), .clr_overrun(clr), .busy(busy),
        .SCK(sck), .CS(cs), .D0(d0), .D1(d1)
    );

    ad1_sample_sched #(
        .NUM_REQ(2), .CLK_DIV(4), .QUIET_CYC(8), .DUAL_MODE(0)
    ) dut_s (
        .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
        .req(req), .gnt(g2), .period(period),
        .smp_valid(v2), .smp_ready(smp_ready),
        .smp_id(id2), .smp_ch0(c20), .smp_ch1(c21),
        .overrun(ov2), .clr_overrun(clr), .busy(b2),
        .SCK(sck2), .CS(cs2), .D0(d0), .D1(d1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ADC model: bit index follows SCK rising edges while CS is low
    always @(posedge sck or posedge cs) begin
        if (cs) bidx = 0;
        else bidx = bidx + 1;
    end

    assign d0 = (bidx < 16) ? f0[15-bidx] : 1'b0;
    assign d1 = (bidx < 16) ? f1[15-bidx] : 1'b0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic int rr_pick(input logic [1:0] r, input int p);
        for (int i = 0; i < 2; i++) begin
            int k;
            k = (p + i) % 2;
            if (r[k]) return k;
        end
        return 0;
    endfunction

    // Push expectations at each grant, compare at each handshake
    always @(negedge clk) begin
        exp_t e;
        int   k;
        if (gnt != 2'b00) g_cnt++;
        if (smp_valid) v_cnt++;
        if (rst_n && busy && !p_busy) begin
            e.c0   = f0[11:0];
            e.c1   = f1[11:0];
            e.gcyc = cyc - 1;
            if (p_req == 2'b00) begin
                e.id = 4'd15;
                t_g.push_back(cyc - 1);
                chk("tmr_gnt", {30'd0, p_gnt}, 32'd0);
            end else begin
                k = rr_pick(p_req, m_ptr);
                chk("gnt", {30'd0, p_gnt}, 32'(1 << k));
                e.id  = 4'(k);
                m_ptr = (k + 1) % 2;
            end
            sb.push_back(e);
        end
        if (smp_valid && !p_valid) v_cyc = cyc;
        if (rst_n && smp_valid && smp_ready) begin
            if (sb.size() == 0) begin
                chk("sb_empty", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("id", {28'd0, smp_id}, {28'd0, e.id});
                chk("ch0", {20'd0, ch0}, {20'd0, e.c0});
                chk("ch1", {20'd0, ch1}, {20'd0, e.c1});
                chk("lat", v_cyc - e.gcyc, 138);
                chk("v_single", {31'd0, v2}, 32'd1);
                chk("ch1_single", {20'd0, c21}, 32'd0);
            end
        end
        p_busy  = busy;
        p_valid = smp_valid;
        p_req   = req;
        p_gnt   = gnt;
    end

    task automatic wait_gnt(output int idx);
        idx = -1;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (gnt != 2'b00) begin
                idx = gnt[1] ? 1 : 0;
                break;
            end
        end
        if (idx < 0) chk("gnt_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        int run;
        run = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!busy) run++;
            else run = 0;
            if (run >= 4) break;
        end
        if (run < 4) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #(200000 * 10);
        $display("FAIL watchdog: simulation did not end");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int ord[3];
        int gc;
        int vc;

        rst_n = 1'b0;
        req   = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt", {30'd0, gnt}, 32'd0);
        chk("rst_valid", {31'd0, smp_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_cs", {31'd0, cs}, 32'd1);
        chk("rst_sck", {31'd0, sck}, 32'd1);
        chk("rst_ovr", {31'd0, overrun}, 32'd0);
        chk("rst_ch0", {20'd0, ch0}, 32'd0);
        chk("rst_id", {28'd0, smp_id}, 32'd0);
        req = 2'b00;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // both requesters held: round-robin order from a fresh pointer
        #1;
        f0  = 16'h35A7;
        f1  = 16'hC3C3;
        req = 2'b11;
        for (int n = 0; n < 3; n++) begin
            wait_gnt(g);
            ord[n] = g;
        end
        @(posedge clk);
        #1;
        req = 2'b00;
        chk("ord0", ord[0], 0);
        chk("ord1", ord[1], 1);
        chk("ord2", ord[2], 0);
        wait_idle();

        // single requester, reference frame
        @(posedge clk);
        #1;
        f0  = 16'b0000_1010_1100_0011;
        f1  = 16'h0F5A;
        req = 2'b01;
        wait_gnt(g);
        chk("g_req0", g, 0);
        @(posedge clk);
        #1;
        req = 2'b00;
        gc  = g_cnt;
        repeat (20) @(posedge clk);
        #1;
        req = 2'b10;
        repeat (20) @(posedge clk);
        #1;
        req = 2'b00;
        wait_idle();
        chk("drop_no_gnt", g_cnt - gc, 0);

        // periodic timer conversions
        @(posedge clk);
        #1;
        f0 = 16'h9123;
        f1 = 16'h6ABC;
        t_g.delete();
        period = 16'd300;
        repeat (1000) @(posedge clk);
        #1;
        chk("tmr_count", {31'd0, t_g.size() >= 3}, 32'd1);
        if (t_g.size() >= 3) begin
            chk("tmr_int1", t_g[1] - t_g[0], 300);
            chk("tmr_int2", t_g[2] - t_g[1], 300);
        end
        chk("ovr_300", {31'd0, overrun}, 32'd0);
        period = 16'd0;
        wait_idle();

        // fast timer against a stalled consumer
        @(posedge clk);
        #1;
        f0        = 16'h5E01;
        f1        = 16'hA7FE;
        smp_ready = 1'b0;
        period    = 16'd50;
        repeat (600) @(posedge clk);
        #1;
        chk("ovr_set", {31'd0, overrun}, 32'd1);
        chk("stall_valid", {31'd0, smp_valid}, 32'd1);
        chk("stall_id", {28'd0, smp_id}, 32'd15);
        chk("stall_ch0", {20'd0, ch0}, 32'h E01);
        chk("stall_ch1", {20'd0, ch1}, 32'h7FE);
        period = 16'd0;
        @(posedge clk);
        #1;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        chk("ovr_clr", {31'd0, overrun}, 32'd0);
        smp_ready = 1'b1;
        wait_idle();

        // reset at the 7th SCK rising edge aborts the frame
        @(posedge clk);
        #1;
        f0  = 16'h0FFF;
        f1  = 16'h0FFF;
        req = 2'b01;
        wait_gnt(g);
        @(posedge clk);
        #1;
        req = 2'b00;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bidx >= 7) break;
        end
        chk("at_edge7", bidx, 7);
        chk("sck_hi7", {31'd0, sck}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_cs", {31'd0, cs}, 32'd1);
        chk("abort_sck", {31'd0, sck}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        sb.delete();
        m_ptr = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        vc = v_cnt;
        repeat (300) @(posedge clk);
        #1;
        chk("no_valid", v_cnt - vc, 0);
        wait_idle();
        chk("sb_left", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ad1_sample_sched.md
AD1_SAMPLE_SCHED -- requirements
Module: ad1_sample_sched

Interface
REQ-001 Parameter NUM_REQ, default 2: number of external sample requesters (1..8).
REQ-002 Parameter CLK_DIV, default 4: SCK half-period in s_axi_aclk cycles (>=1).
REQ-003 Parameter QUIET_CYC, default 8: minimum CS-high cycles between conversions.
REQ-004 Parameter DUAL_MODE, default 1: 1 = capture D0 and D1; 0 = D1 ignored, smp_ch1 reads 0.
REQ-005 s_axi_aclk  in  1  sole clock; all logic on rising edge.
REQ-006 s_axi_aresetn  in  1  asynchronous, active-low reset.
REQ-007 req  in  NUM_REQ  level sample requests; held until matching gnt bit.
REQ-008 gnt  out  NUM_REQ  one-hot, one-cycle grant pulse.
REQ-009 period  in  16  timer period in s_axi_aclk cycles; 0 disables timer.
REQ-010 smp_valid / smp_ready  out / in  1 / 1  result handshake.
REQ-011 smp_id  out  4  source of result: 0..NUM_REQ-1 = requester, 15 = timer.
REQ-012 smp_ch0, smp_ch1  out  12 each  converted codes, MSB-aligned bit 11.
REQ-013 overrun  out  1  sticky; timer tick lost; cleared by clr_overrun (in, 1).
REQ-014 busy  out  1  high outside IDLE.
REQ-015 SCK, CS  out  1 each  Pmod AD1 clock and active-low chip select; D0, D1  in  1 each.

Function
REQ-016 FSM states IDLE, START, SHIFT, QUIET, OUT; unlisted encodings go to IDLE.
REQ-017 IDLE: if timer pending or any req, arbitrate and go START; else stay.
REQ-018 Arbitration: pending timer tick wins; else round-robin among req, pointer moves to one past last granted index.
REQ-019 gnt pulses in the IDLE->START cycle; timer grant clears the pending flag instead.
REQ-020 START: CS driven low one cycle after grant; SHIFT entered next cycle.
REQ-021 SHIFT: SCK toggles every CLK_DIV cycles starting low; exactly 16 rising edges; D0/D1 sampled on each rising edge into 16-bit shifters, MSB first.
REQ-022 After 16th rising edge and CLK_DIV cycles high, CS returns high, go QUIET; SCK high whenever not in SHIFT.
REQ-023 Results = shifter bits [11:0]; leading 4 bits discarded, not checked.
REQ-024 QUIET lasts QUIET_CYC cycles, then OUT.
REQ-025 OUT: smp_valid high with stable id/data until smp_ready; handshake cycle -> IDLE.
REQ-026 Conversion latency grant->smp_valid = 2 + 32*CLK_DIV + QUIET_CYC cycles.
REQ-027 Timer: 16-bit down-counter reloaded with period; terminal count sets pending flag; counts in all states.
REQ-028 Tick while flag already set: set overrun; clr_overrun and tick same cycle -> overrun stays 1.
REQ-029 period change takes effect at next reload; period written 0 -> counter halts, pending flag kept.
REQ-030 req dropped before grant: no grant, no conversion.

Reset
REQ-031 Reset asserted: state IDLE, CS=1, SCK=1, gnt=0, smp_valid=0, overrun=0, pending=0, RR pointer=0, timer loaded with period, data outputs 0.
REQ-032 Reset mid-conversion aborts immediately (CS/SCK high asynchronously); no result emitted.

Structure
REQ-033 Package ad1_pkg: FSM state type, TIMER_ID=15, ID width 4, AD1 frame length 16, data width 12.
REQ-034 One sub-module ad1_rr_arbiter (NUM_REQ requests, enable, one-hot grant, pointer update).

Verification
REQ-035 CLK_DIV=4, QUIET_CYC=8, req=01, D0 stream 0000_1010_1100_0011 -> gnt=01, smp_ch0=0xAC3, smp_id=0, smp_valid 138 cycles after grant.
REQ-036 req=11 held for three conversions -> grant order 0,1,0.
REQ-037 period=300, req idle, smp_ready=1 -> conversion each 300 cycles, smp_id=15, overrun stays 0.
REQ-038 period=50, smp_ready=0 for 400 cycles -> overrun=1, smp_valid and data stable; clr_overrun -> 0.
REQ-039 Reset at 7th SCK rising edge -> CS=1, SCK=1 same cycle, no smp_valid after release.
REQ-040 DUAL_MODE=0, D1 toggling -> smp_ch1=0 always.
